// File: rtl/time_display_pkg.sv
// Shared constants for time_display: active-low 7-segment patterns {g,f,e,d,c,b,a},
// field-select codes and scan digit bounds.
package time_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      FIELD_HOURS   = 2'd0,
      FIELD_MINUTES = 2'd1,
      FIELD_SECONDS = 2'd2,
      FIELD_NONE    = 2'd3
   } field_e;

   // Scan runs from the hours tens digit down to the seconds units digit.
   localparam logic [2:0] DIGIT_FIRST = 3'd5;
   localparam logic [2:0] DIGIT_LAST  = 3'd0;

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/time_display_bin2bcd_60.sv
// Combinational 6-bit binary to two-digit BCD with an out-of-range flag (value > MAX_VAL).
module bin2bcd_60 #(
   parameter int MAX_VAL = 59
) (
   input  logic [5:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       oor
);

   logic [5:0] rem;

   always_comb begin
      oor  = (bin > 6'(MAX_VAL));
      tens = 4'd0;
      // Descending compare ladder: the first threshold met is the tens digit.
      for (int t = 6; t >= 1; t--) begin
         if (tens == 4'd0 && bin >= 6'(t * 10)) begin
            tens = 4'(t);
         end
      end
      rem   = bin - (6'(tens) * 6'd10);
      units = rem[3:0];
   end

endmodule

// File: rtl/time_display.sv
// Six-digit multiplexed HH.MM.SS driver with per-frame input snapshot and registered outputs.
// Optional edit-field blinking is compiled in with TIME_DISPLAY_BLINK_EN.
module time_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       edit_en,
   input  logic [1:0] edit_field,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       dp
);
   import time_display_pkg::*;

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0] pre_cnt_reg;
   logic          tick;
   logic          active_reg;
   logic [2:0]    digit_reg, digit_next;
   logic          frame_start;
   logic [4:0]    hours_snap_reg;
   logic [5:0]    minutes_snap_reg, seconds_snap_reg;
   logic [6:0]    seg_reg, seg_next;
   logic [5:0]    an_reg, an_next;
   logic          dp_reg, dp_next;
   logic [1:0]    field_sel;
   logic          blank_sel;

   logic [5:0]    field_bin [3];
   logic [3:0]    tens_w    [3];
   logic [3:0]    units_w   [3];
   logic          oor_w     [3];

   assign tick = (pre_cnt_reg == CW'(REFRESH_DIV - 1));

   // The first tick after reset only enters digit 5; later ticks step down and wrap.
   always_comb begin
      digit_next  = digit_reg;
      frame_start = 1'b0;
      if (tick) begin
         if (!active_reg) begin
            frame_start = 1'b1;
         end else if (digit_reg == DIGIT_LAST) begin
            digit_next  = DIGIT_FIRST;
            frame_start = 1'b1;
         end else begin
            digit_next = digit_reg - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_reg      <= '0;
         active_reg       <= 1'b0;
         digit_reg        <= DIGIT_FIRST;
         hours_snap_reg   <= '0;
         minutes_snap_reg <= '0;
         seconds_snap_reg <= '0;
         seg_reg          <= SEG_BLANK;
         an_reg           <= 6'b111111;
         dp_reg           <= 1'b1;
      end else begin
         pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
         if (tick) begin
            active_reg <= 1'b1;
         end
         digit_reg <= digit_next;
         if (frame_start) begin
            hours_snap_reg   <= hours;
            minutes_snap_reg <= minutes;
            seconds_snap_reg <= seconds;
         end
         seg_reg <= seg_next;
         an_reg  <= an_next;
         dp_reg  <= dp_next;
      end
   end

   assign field_bin[0] = {1'b0, hours_snap_reg};
   assign field_bin[1] = minutes_snap_reg;
   assign field_bin[2] = seconds_snap_reg;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_field
         bin2bcd_60 #(
            .MAX_VAL((gi == 0) ? 23 : 59)
         ) u_bcd (
            .bin  (field_bin[gi]),
            .tens (tens_w[gi]),
            .units(units_w[gi]),
            .oor  (oor_w[gi])
         );
      end
   endgenerate

`ifdef TIME_DISPLAY_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BW-1:0] blink_cnt_reg;
   logic          blink_on_reg;
   logic          edit_en_snap_reg;
   logic [1:0]    edit_field_snap_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_reg       <= '0;
         blink_on_reg        <= 1'b1;
         edit_en_snap_reg    <= 1'b0;
         edit_field_snap_reg <= 2'd0;
      end else begin
         if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
         if (frame_start) begin
            edit_en_snap_reg    <= edit_en;
            edit_field_snap_reg <= edit_field;
         end
      end
   end

   // FIELD_NONE never equals a displayed field, so it never blanks.
   assign blank_sel = edit_en_snap_reg && (edit_field_snap_reg == field_sel) && !blink_on_reg;
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_edit;
   assign unused_edit = ^{edit_en, edit_field};
   assign blank_sel   = 1'b0;
`endif

   always_comb begin
      case (digit_reg)
         3'd5, 3'd4: field_sel = FIELD_HOURS;
         3'd3, 3'd2: field_sel = FIELD_MINUTES;
         default:    field_sel = FIELD_SECONDS;
      endcase
   end

   always_comb begin
      seg_next = SEG_BLANK;
      an_next  = 6'b111111;
      dp_next  = 1'b1;
      if (active_reg) begin
         an_next = ~(6'b000001 << digit_reg);
         dp_next = !((digit_reg == 3'd4) || (digit_reg == 3'd2));
         if (blank_sel) begin
            seg_next = SEG_BLANK;
         end else if (oor_w[field_sel]) begin
            seg_next = SEG_DASH;
         end else begin
            seg_next = seg_decode(digit_reg[0] ? tens_w[field_sel] : units_w[field_sel]);
         end
      end
   end

   assign seg = seg_reg;
   assign an  = an_reg;
   assign dp  = dp_reg;

endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display: a cycle-indexed reference model queues the expected
// digit for every scan slot, and a monitor checks each new digit the DUT presents.
module tb_time_display;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] hours = '0;
   logic [5:0] minutes = '0;
   logic [5:0] seconds = '0;
   logic       edit_en = 1'b0;
   logic [1:0] edit_field = 2'd3;
   logic [6:0] seg;
   logic [5:0] an;
   logic       dp;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   time_display #(
      .REFRESH_DIV(REFRESH_DIV),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hours     (hours),
      .minutes   (minutes),
      .seconds   (seconds),
      .edit_en   (edit_en),
      .edit_field(edit_field),
      .seg       (seg),
      .an        (an),
      .dp        (dp)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] SEG_TAB [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   // Expected entries are {an, seg, dp}.
   logic [13:0] exp_q [$];

   // Reference model: k counts clock edges since reset release. A slot tick lands on
   // every REFRESH_DIV-th edge; slot m shows digit 5 - ((m-1) mod 6) from the next edge.
   int k = 0;
   int snap_h, snap_m, snap_s, snap_e, snap_f;
   always @(posedge clk) begin
      int m, pos, digit, field, val, maxv, d;
      logic [6:0] s;
      logic [5:0] a;
      logic       p;
      if (rst) begin
         k = 0;
         exp_q.delete();
      end else begin
         k++;
         if (k % REFRESH_DIV == 0) begin
            m   = k / REFRESH_DIV;
            pos = (m - 1) % 6;
            digit = 5 - pos;
            if (pos == 0) begin
               snap_h = int'(hours);
               snap_m = int'(minutes);
               snap_s = int'(seconds);
               snap_e = int'(edit_en);
               snap_f = int'(edit_field);
            end
            field = pos / 2;
            val   = (field == 0) ? snap_h : (field == 1) ? snap_m : snap_s;
            maxv  = (field == 0) ? 23 : 59;
            d     = (pos % 2 == 0) ? val / 10 : val % 10;
            s     = (val > maxv) ? 7'b0111111 : SEG_TAB[d];
`ifdef TIME_DISPLAY_BLINK_EN
            if (snap_e == 1 && snap_f == field && ((k / BLINK_DIV) % 2) == 1) begin
               s = 7'b1111111;
            end
`endif
            a = 6'b111111;
            a[digit] = 1'b0;
            p = !(digit == 4 || digit == 2);
            exp_q.push_back({a, s, p});
         end
      end
   end

   // Monitor: each change of an is a new digit slot; while an holds, outputs must hold.
   logic [5:0]  prev_an = 6'b111111;
   logic [13:0] last_exp = '0;
   bit          have_last = 1'b0;
   always @(negedge clk) begin
      logic [13:0] e;
      if (an !== prev_an && an !== 6'b111111) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scan_unexpected: an=%b seg=%b dp=%b, required no new digit", an, seg, dp);
         end else begin
            e = exp_q.pop_front();
            n_pops++;
            if ({an, seg, dp} !== e) begin
               n_fail++;
               $display("[TB] FAIL digit: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                        an, seg, dp, e[13:8], e[7:1], e[0]);
            end else begin
               $display("[TB] digit an=%b seg=%b dp=%b ok", an, seg, dp);
            end
            last_exp  = e;
            have_last = 1'b1;
         end
      end else if (an === prev_an && an !== 6'b111111 && have_last) begin
         n_tests++;
         if ({an, seg, dp} !== last_exp) begin
            n_fail++;
            $display("[TB] FAIL hold: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                     an, seg, dp, last_exp[13:8], last_exp[7:1], last_exp[0]);
         end
      end
      prev_an = an;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_blank(input string name);
      n_tests++;
      if ({seg, an, dp} !== {7'h7F, 6'h3F, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL %s: seg=%h an=%h dp=%b, required seg=7f an=3f dp=1", name, seg, an, dp);
      end else begin
         $display("[TB] %s seg=%h an=%h dp=%b ok", name, seg, an, dp);
      end
   endtask

   initial begin
      // Reset held three cycles.
      step(3);
      check_blank("reset_hold");

      // 13:07:42, with minutes moved to 8 while digit 3 of the first frame is showing.
      hours = 5'd13; minutes = 6'd7; seconds = 6'd42;
      rst = 1'b0;
      step(14);
      minutes = 6'd8;
      step(50);

      // Out-of-range fields show dashes.
      hours = 5'd25; minutes = 6'd34; seconds = 6'd60;
      step(52);
      hours = 5'd31; minutes = 6'd63; seconds = 6'd59;
      step(30);
      hours = 5'd23; minutes = 6'd59; seconds = 6'd0;
      step(30);

      // Edit blinking on minutes, then the other fields, then no field.
      hours = 5'd9; minutes = 6'd45; seconds = 6'd18;
      edit_en = 1'b1; edit_field = 2'd1;
      step(300);
      edit_field = 2'd0;
      step(140);
      edit_field = 2'd2;
      step(140);
      edit_field = 2'd3;
      step(140);
      edit_en = 1'b0;

      // Reset in the middle of a frame, then restart from digit 5.
      step(9);
      rst = 1'b1;
      step(2);
      check_blank("reset_mid_frame");
      rst = 1'b0;
      step(60);

      // Random traffic, including mid-frame changes and out-of-range values.
      for (int i = 0; i < 40; i++) begin
         hours      = 5'($urandom_range(0, 31));
         minutes    = 6'($urandom_range(0, 63));
         seconds    = 6'($urandom_range(0, 63));
         edit_en    = 1'($urandom_range(0, 1));
         edit_field = 2'($urandom_range(0, 3));
         step($urandom_range(1, 30));
      end
      step(6);

      // At any negedge at most one queued slot may still await presentation.
      n_tests++;
      if (exp_q.size() > 1) begin
         n_fail++;
         $display("[TB] FAIL backlog: %0d pending slots, required at most 1", exp_q.size());
      end
      n_tests++;
      if (n_pops < 300) begin
         n_fail++;
         $display("[TB] FAIL slot_count: %0d digits observed, required at least 300", n_pops);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
